// File: rtl/hsl2rgb_stream.sv
// hsl2rgb_stream: five-stage streaming HSL/HSV to RGB converter with a
// valid/ready handshake. The whole pipe advances together and freezes when
// the output register holds a result that downstream has not taken.
module hsl2rgb_stream #(
    parameter int W  = 8,
    parameter int TW = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mode,
    input  logic [W-1:0]  h,
    input  logic [W-1:0]  s,
    input  logic [W-1:0]  l,
    input  logic [TW-1:0] tag_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [W-1:0]  r,
    output logic [W-1:0]  g,
    output logic [W-1:0]  b,
    output logic [TW-1:0] tag_o,
    output logic          valid_o,
    input  logic          ready_i
);

    localparam int N  = 1 << W;
    localparam int LW = 2 * W;      // L*S product width
    localparam int SW = 2 * W + 1;  // signed working width for Q/P before clamping
    localparam int PW = 2 * W + 4;  // 6*D*f product width (< 6*N*N)
    localparam int XW = W + 4;      // channel sum width before saturation

    localparam logic [W-1:0] C16  = W'((N + 3) / 6);
    localparam logic [W-1:0] C13  = W'((N + 1) / 3);
    localparam logic [W-1:0] C12  = W'(N / 2);
    localparam logic [W-1:0] C23  = W'((2 * N + 1) / 3);
    localparam logic [W-1:0] MAXV = W'(N - 1);

    // Clamp a signed intermediate into [0, N-1].
    function automatic logic [W-1:0] clamp_s(input logic signed [SW-1:0] v);
        logic [W-1:0] res;
        if (v[SW-1])
            res = '0;
        else if (v > $signed(SW'(MAXV)))
            res = MAXV;
        else
            res = W'(v);
        return res;
    endfunction

    // Saturate a non-negative channel sum to N-1.
    function automatic logic [W-1:0] sat_x(input logic [XW-1:0] v);
        return (v > XW'(MAXV)) ? MAXV : W'(v);
    endfunction

    // Multiplier for the ramp segments; zero on the flat segments.
    function automatic logic [W-1:0] ramp_arg(input logic [W-1:0] t);
        logic [W-1:0] f;
        if (t < C16)
            f = t;
        else if (t < C12)
            f = '0;
        else if (t < C23)
            f = C23 - t;
        else
            f = '0;
        return f;
    endfunction

    // True on the segment where the channel equals Q.
    function automatic logic on_plateau(input logic [W-1:0] t);
        return (t >= C16) && (t < C12);
    endfunction

    logic          en;
    logic          vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q, valid_o_q;
    logic          vld_p0_d, vld_p1_d, vld_p2_d, vld_p3_d, valid_o_d;

    logic          mode_p0_q, mode_p0_d;
    logic [W-1:0]  h_p0_q, h_p0_d, s_p0_q, s_p0_d, l_p0_q, l_p0_d;
    logic [TW-1:0] tag_p0_q, tag_p0_d;

    logic          mode_p1_q, mode_p1_d;
    logic [W-1:0]  h_p1_q, h_p1_d, s_p1_q, s_p1_d, l_p1_q, l_p1_d;
    logic [LW-1:0] ls_p1_q, ls_p1_d;
    logic [TW-1:0] tag_p1_q, tag_p1_d;

    logic signed [SW-1:0] lx, sx, lsd, qx, q_raw, p_raw;
    logic [W-1:0]  q_p2_q, q_p2_d, p_p2_q, p_p2_d, d_p2_q, d_p2_d;
    logic [W-1:0]  t_p2_q [3];
    logic [W-1:0]  t_p2_d [3];
    logic [TW-1:0] tag_p2_q, tag_p2_d;

    logic [W-1:0]  base_p3_q [3];
    logic [W-1:0]  base_p3_d [3];
    logic [PW-1:0] prod_p3_q [3];
    logic [PW-1:0] prod_p3_d [3];
    logic [TW-1:0] tag_p3_q, tag_p3_d;

    logic [W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic [TW-1:0] tag_o_q, tag_o_d;

    assign en      = ready_i || !valid_o_q;
    assign ready_o = en && !reset;
    assign r       = r_q;
    assign g       = g_q;
    assign b       = b_q;
    assign tag_o   = tag_o_q;
    assign valid_o = valid_o_q;

    // Valid bits shift one stage per enabled cycle, independent of data.
    always_comb begin
        vld_p0_d  = valid_i;
        vld_p1_d  = vld_p0_q;
        vld_p2_d  = vld_p1_q;
        vld_p3_d  = vld_p2_q;
        valid_o_d = vld_p3_q;
    end

    // Valid chain register; reset empties the pipe.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            valid_o_q <= 1'b0;
        end else if (en) begin
            vld_p0_q  <= vld_p0_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            vld_p3_q  <= vld_p3_d;
            valid_o_q <= valid_o_d;
        end
    end

    // Stage p0: capture the incoming pixel.
    always_comb begin
        mode_p0_d = mode;
        h_p0_d    = h;
        s_p0_d    = s;
        l_p0_d    = l;
        tag_p0_d  = tag_i;
    end

    // Stage p1: L*S product.
    always_comb begin
        mode_p1_d = mode_p0_q;
        h_p1_d    = h_p0_q;
        s_p1_d    = s_p0_q;
        l_p1_d    = l_p0_q;
        tag_p1_d  = tag_p0_q;
        ls_p1_d   = LW'(l_p0_q) * LW'(s_p0_q);
    end

    // Stage p2: clamped Q and P, span D, per-channel hue offsets.
    always_comb begin
        lx  = $signed(SW'(l_p1_q));
        sx  = $signed(SW'(s_p1_q));
        lsd = $signed(SW'(ls_p1_q >> W));
        if (mode_p1_q)
            q_raw = lx;
        else if (l_p1_q < C12)
            q_raw = lx + lsd;
        else
            q_raw = lx + sx - lsd;
        q_p2_d = clamp_s(q_raw);
        qx     = $signed(SW'(q_p2_d));
        // HSL derives P from the already-clamped Q.
        if (mode_p1_q)
            p_raw = lx - lsd;
        else
            p_raw = (lx <<< 1) - qx;
        p_p2_d   = clamp_s(p_raw);
        d_p2_d   = (q_p2_d > p_p2_d) ? (q_p2_d - p_p2_d) : '0;
        t_p2_d[0] = h_p1_q + C13;
        t_p2_d[1] = h_p1_q;
        t_p2_d[2] = h_p1_q - C13;
        tag_p2_d = tag_p1_q;
    end

    // Stage p3: segment select and 6*D*f ramp product per channel.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            base_p3_d[i] = on_plateau(t_p2_q[i]) ? q_p2_q : p_p2_q;
            prod_p3_d[i] = PW'(d_p2_q) * PW'(ramp_arg(t_p2_q[i])) * PW'(6);
        end
        tag_p3_d = tag_p2_q;
    end

    // Stage p4: base plus scaled ramp, saturated.
    always_comb begin
        r_d     = sat_x(XW'(base_p3_q[0]) + XW'(prod_p3_q[0] >> W));
        g_d     = sat_x(XW'(base_p3_q[1]) + XW'(prod_p3_q[1] >> W));
        b_d     = sat_x(XW'(base_p3_q[2]) + XW'(prod_p3_q[2] >> W));
        tag_o_d = tag_p3_q;
    end

    // Internal data registers; they hold whenever the pipe is stalled.
    always_ff @(posedge clock) begin
        if (en) begin
            mode_p0_q <= mode_p0_d;
            h_p0_q    <= h_p0_d;
            s_p0_q    <= s_p0_d;
            l_p0_q    <= l_p0_d;
            tag_p0_q  <= tag_p0_d;
            mode_p1_q <= mode_p1_d;
            h_p1_q    <= h_p1_d;
            s_p1_q    <= s_p1_d;
            l_p1_q    <= l_p1_d;
            ls_p1_q   <= ls_p1_d;
            tag_p1_q  <= tag_p1_d;
            q_p2_q    <= q_p2_d;
            p_p2_q    <= p_p2_d;
            d_p2_q    <= d_p2_d;
            t_p2_q    <= t_p2_d;
            tag_p2_q  <= tag_p2_d;
            base_p3_q <= base_p3_d;
            prod_p3_q <= prod_p3_d;
            tag_p3_q  <= tag_p3_d;
        end
    end

    // Output register; cleared by reset, frozen while downstream stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            tag_o_q <= '0;
        end else if (en) begin
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            tag_o_q <= tag_o_d;
        end
    end

endmodule

// File: tb/tb_hsl2rgb_stream.sv
// tb_hsl2rgb_stream: directed and randomized checks of hsl2rgb_stream against
// an integer colour model and a FIFO scoreboard.
module tb_hsl2rgb_stream;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int N  = 1 << W;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          mode    = 1'b0;
    logic [W-1:0]  h       = '0;
    logic [W-1:0]  s       = '0;
    logic [W-1:0]  l       = '0;
    logic [TW-1:0] tag_i   = '0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b1;
    logic          ready_o;
    logic [W-1:0]  r, g, b;
    logic [TW-1:0] tag_o;
    logic          valid_o;

    typedef struct packed {
        logic [W-1:0]  r;
        logic [W-1:0]  g;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    logic hold_vld = 1'b0;
    int   held     = 0;
    int   n_out    = 0;
    int   nvec     = 0;
    int   nfail    = 0;
    int   mr, mg, mb;

    hsl2rgb_stream #(.W(W), .TW(TW)) dut (
        .clock  (clock),
        .reset  (reset),
        .mode   (mode),
        .h      (h),
        .s      (s),
        .l      (l),
        .tag_i  (tag_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .r      (r),
        .g      (g),
        .b      (b),
        .tag_o  (tag_o),
        .valid_o(valid_o),
        .ready_i(ready_i)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Colour conversion straight from the arithmetic definition.
    function automatic void model(input int m, input int hh, input int ss, input int ll,
                                  output int ro, output int go, output int bo);
        int c16, c13, c12, c23, q, p, d;
        int t[3];
        int x[3];
        c16 = (N + 3) / 6;
        c13 = (N + 1) / 3;
        c12 = N / 2;
        c23 = (2 * N + 1) / 3;
        if (m != 0) begin
            q = ll;
            p = ll - (ll * ss) / N;
        end else begin
            if (ll < c12) q = ll + (ll * ss) / N;
            else          q = ll + ss - (ll * ss) / N;
            if (q > N - 1) q = N - 1;
            p = 2 * ll - q;
        end
        if (q > N - 1) q = N - 1;
        if (p < 0) p = 0;
        if (p > N - 1) p = N - 1;
        d = q - p;
        t[0] = (hh + c13) % N;
        t[1] = hh;
        t[2] = (hh - c13 + N) % N;
        for (int i = 0; i < 3; i++) begin
            if (t[i] < c16)      x[i] = p + (6 * d * t[i]) / N;
            else if (t[i] < c12) x[i] = q;
            else if (t[i] < c23) x[i] = p + (6 * d * (c23 - t[i])) / N;
            else                 x[i] = p;
            if (x[i] > N - 1) x[i] = N - 1;
        end
        ro = x[0];
        go = x[1];
        bo = x[2];
    endfunction

    // Compare process: handshake, stall stability, scoreboard order and values.
    always @(negedge clock) begin
        #2;
        if (reset) begin
            chk("ready_o_in_reset", int'(ready_o), 0);
            exp_q.delete();
            hold_vld = 1'b0;
        end else begin
            chk("ready_o", int'(ready_o), (ready_i || !valid_o) ? 1 : 0);
            if (hold_vld) begin
                chk("stall_valid", int'(valid_o), 1);
                chk("stall_data", int'({r, g, b, tag_o}), held);
            end
            hold_vld = 1'b0;
            if (valid_o) begin
                if (ready_i) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL spurious_output: got rgb %0d/%0d/%0d tag %0d, expected none",
                                 r, g, b, tag_o);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("out_r", int'(r), int'(mon_e.r));
                        chk("out_g", int'(g), int'(mon_e.g));
                        chk("out_b", int'(b), int'(mon_e.b));
                        chk("out_tag", int'(tag_o), int'(mon_e.tag));
                    end
                end else begin
                    hold_vld = 1'b1;
                    held     = int'({r, g, b, tag_o});
                end
            end
            if (valid_i && ready_o) begin
                model(int'(mode), int'(h), int'(s), int'(l), mr, mg, mb);
                exp_q.push_back('{r: W'(mr), g: W'(mg), b: W'(mb), tag: tag_i});
            end
        end
    end

    task automatic drive(input int m, input int hh, input int ss, input int ll, input int tg);
        @(negedge clock);
        mode    = m[0];
        h       = W'(hh);
        s       = W'(ss);
        l       = W'(ll);
        tag_i   = TW'(tg);
        valid_i = 1'b1;
        ready_i = 1'b1;
    endtask

    task automatic idle();
        @(negedge clock);
        valid_i = 1'b0;
        ready_i = 1'b1;
    endtask

    // Send one pixel into an empty pipe and time its arrival.
    task automatic send_timed(input string name, input int m, input int hh, input int ss,
                              input int ll, input int tg, input int er, input int eg, input int eb);
        int k;
        drive(m, hh, ss, ll, tg);
        k = 0;
        do begin
            @(negedge clock);
            valid_i = 1'b0;
            k++;
            #3;
        end while (!valid_o && k < 12);
        chk({name, "_latency"}, k, 5);
        chk({name, "_r"}, int'(r), er);
        chk({name, "_g"}, int'(g), eg);
        chk({name, "_b"}, int'(b), eb);
        chk({name, "_tag"}, int'(tag_o), tg);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        #3;
        while (!valid_o && k < 12) begin
            @(negedge clock);
            #3;
            k++;
        end
        chk({name, "_arrived"}, int'(valid_o), 1);
    endtask

    task automatic expect_out(input string name, input int er, input int eg, input int eb, input int tg);
        chk({name, "_valid"}, int'(valid_o), 1);
        chk({name, "_r"}, int'(r), er);
        chk({name, "_g"}, int'(g), eg);
        chk({name, "_b"}, int'(b), eb);
        chk({name, "_tag"}, int'(tag_o), tg);
        @(negedge clock);
        #3;
    endtask

    initial begin
        int er, eg, eb, base_out;

        // Hand-computed points that pin the model.
        model(0, 0, 255, 128, er, eg, eb);
        chk("pin_hsl_red_r", er, 255);
        chk("pin_hsl_red_g", eg, 1);
        chk("pin_hsl_red_b", eb, 1);
        model(1, 85, 255, 200, er, eg, eb);
        chk("pin_hsv_r", er, 5);
        chk("pin_hsv_g", eg, 200);
        chk("pin_hsv_b", eb, 1);
        model(0, 200, 0, 100, er, eg, eb);
        chk("pin_grey_r", er, 100);
        chk("pin_grey_g", eg, 100);
        chk("pin_grey_b", eb, 100);

        // Reset with a pixel presented: nothing is accepted, outputs cleared.
        mode = 1'b0; h = 8'd10; s = 8'd20; l = 8'd30; tag_i = 4'd3; valid_i = 1'b1;
        repeat (3) @(negedge clock);
        #3;
        chk("reset_valid_o", int'(valid_o), 0);
        chk("reset_out", int'({r, g, b, tag_o}), 0);
        @(negedge clock);
        reset   = 1'b0;
        valid_i = 1'b0;
        repeat (2) @(negedge clock);

        // Single HSL red pixel: latency and exact value.
        send_timed("hsl_red", 0, 0, 255, 128, 5, 255, 1, 1);

        // Three grey pixels back to back come out on consecutive cycles.
        drive(0, 0, 0, 100, 1);
        drive(0, 85, 0, 100, 2);
        drive(0, 200, 0, 100, 3);
        idle();
        wait_valid("grey");
        expect_out("grey0", 100, 100, 100, 1);
        expect_out("grey1", 100, 100, 100, 2);
        expect_out("grey2", 100, 100, 100, 3);

        // Mixed-mode interleave keeps order and tags.
        drive(1, 85, 255, 200, 6);
        drive(0, 0, 255, 128, 7);
        drive(1, 85, 255, 200, 8);
        idle();
        wait_valid("mix");
        expect_out("mix0", 5, 200, 1, 6);
        expect_out("mix1", 255, 1, 1, 7);
        expect_out("mix2", 5, 200, 1, 8);

        // Backpressure: eight tagged pixels, three-cycle stall with output valid.
        repeat (4) idle();
        base_out = n_out;
        for (int i = 0; i < 8; i++)
            drive(0, $urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), i);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            valid_i = 1'b0;
            ready_i = 1'b0;
            #3;
            chk("bp_valid_o", int'(valid_o), 1);
            chk("bp_ready_o", int'(ready_o), 0);
        end
        repeat (12) idle();
        chk("bp_delivered", n_out - base_out, 8);

        // Reset mid-stream with three pixels in flight.
        drive(0, 30, 200, 90, 9);
        drive(1, 120, 100, 180, 10);
        drive(0, 250, 50, 220, 11);
        @(negedge clock);
        reset = 1'b1;
        base_out = n_out;
        @(negedge clock);
        reset   = 1'b0;
        valid_i = 1'b0;
        #3;
        chk("mid_reset_valid_o", int'(valid_o), 0);
        chk("mid_reset_out", int'({r, g, b, tag_o}), 0);
        repeat (8) idle();
        chk("mid_reset_dropped", n_out - base_out, 0);
        model(1, 0, 255, 255, er, eg, eb);
        send_timed("after_reset", 1, 0, 255, 255, 12, er, eg, eb);

        // Randomized stream with bubbles, backpressure and hue boundaries.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clock);
            mode  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       h = '0;
                1:       h = W'(N - 1);
                default: h = W'($urandom_range(0, N - 1));
            endcase
            s       = W'($urandom_range(0, N - 1));
            l       = W'($urandom_range(0, N - 1));
            tag_i   = TW'($urandom_range(0, (1 << TW) - 1));
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 3) != 0);
        end
        repeat (12) idle();
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
